// File: rtl/ctrl_decode_stage.sv
// Decode-stage control generator with a registered E-stage control bundle.
// Define CTRL_MULDIV_EN to add MUL/DIV decode and the multicycle BUSY hold.
module ctrl_decode_stage #(
    parameter int CONTROL_WIDTH = 4,
    parameter int IMM_WIDTH     = 3,
    parameter int MD_LATENCY    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_d,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic                     stall_e,
    input  logic                     flush_e,
    output logic [IMM_WIDTH-1:0]     ImmSrcD,
    output logic                     busy_d,
    output logic                     valid_e,
    output logic [2:0]               RegWriteE,
    output logic [1:0]               MemWriteE,
    output logic [1:0]               ResultsrcE,
    output logic [CONTROL_WIDTH-1:0] ALUctrlE,
    output logic                     ALUsrcE,
    output logic                     ALUsrcAE,
    output logic [1:0]               JumpE,
    output logic                     BranchE,
    output logic [2:0]               BrTypeE,
    output logic                     IllegalE
);
    // state | meaning
    // IDLE  | E bundle accepts a new instruction on each unstalled edge
    // BUSY  | MUL/DIV occupies E; bundle held, counter counts down
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2,  ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4,  ALU_SLT  = 4'd5,  ALU_SLTU = 4'd6,  ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8,  ALU_SRA  = 4'd9,  ALU_PASSB = 4'd10, ALU_MUL = 4'd11;
    localparam logic [3:0] ALU_MULH = 4'd12, ALU_DIV = 4'd13, ALU_REM  = 4'd14;

    typedef struct packed {
        logic                     valid;
        logic [2:0]               reg_write;
        logic [1:0]               mem_write;
        logic [1:0]               result_src;
        logic [CONTROL_WIDTH-1:0] alu_ctrl;
        logic                     alu_src;
        logic                     alu_src_a;
        logic [1:0]               jump;
        logic                     branch;
        logic [2:0]               br_type;
        logic                     illegal;
    } bundle_t;

    bundle_t    dec, bundle_d, bundle_q;
    logic       dec_ok;
    logic [3:0] alu_base, alu_sel;
    logic       md_hold;

    always_comb begin
        case (opcode)
            OP_STORE:          ImmSrcD = IMM_WIDTH'(3'b001);
            OP_BRANCH:         ImmSrcD = IMM_WIDTH'(3'b010);
            OP_JAL:            ImmSrcD = IMM_WIDTH'(3'b011);
            OP_LUI, OP_AUIPC:  ImmSrcD = IMM_WIDTH'(3'b100);
            default:           ImmSrcD = IMM_WIDTH'(3'b000);
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  alu_base = ALU_ADD;
            3'b001:  alu_base = ALU_SLL;
            3'b010:  alu_base = ALU_SLT;
            3'b011:  alu_base = ALU_SLTU;
            3'b100:  alu_base = ALU_XOR;
            3'b101:  alu_base = ALU_SRL;
            3'b110:  alu_base = ALU_OR;
            default: alu_base = ALU_AND;
        endcase
    end

    always_comb begin
        dec     = '0;
        dec_ok  = 1'b1;
        alu_sel = ALU_ADD;
        case (opcode)
            OP_LOAD: begin
                dec.result_src = 2'b01;
                dec.alu_src    = 1'b1;
                case (funct3)
                    3'b000:  dec.reg_write = 3'b011;
                    3'b001:  dec.reg_write = 3'b010;
                    3'b010:  dec.reg_write = 3'b001;
                    3'b100:  dec.reg_write = 3'b111;
                    3'b101:  dec.reg_write = 3'b110;
                    default: dec_ok = 1'b0;
                endcase
            end
            OP_STORE: begin
                dec.alu_src = 1'b1;
                case (funct3)
                    3'b000:  dec.mem_write = 2'b11;
                    3'b001:  dec.mem_write = 2'b10;
                    3'b010:  dec.mem_write = 2'b01;
                    default: dec_ok = 1'b0;
                endcase
            end
            OP_R: begin
                dec.reg_write = 3'b001;
                if (funct7 == 7'b0000000) alu_sel = alu_base;
                else if (funct7 == F7_ALT && funct3 == 3'b000) alu_sel = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101) alu_sel = ALU_SRA;
`ifdef CTRL_MULDIV_EN
                else if (funct7 == F7_MULDIV) begin
                    case (funct3)
                        3'b000:  alu_sel = ALU_MUL;
                        3'b001:  alu_sel = ALU_MULH;
                        3'b100:  alu_sel = ALU_DIV;
                        3'b110:  alu_sel = ALU_REM;
                        default: dec_ok = 1'b0;
                    endcase
                end
`endif
                else dec_ok = 1'b0;
            end
            OP_I: begin
                // funct7 is immediate data except on shifts
                dec.reg_write = 3'b001;
                dec.alu_src   = 1'b1;
                if (funct3 == 3'b001 && funct7 != 7'b0000000) dec_ok = 1'b0;
                else if (funct3 == 3'b101 && funct7 == F7_ALT) alu_sel = ALU_SRA;
                else if (funct3 == 3'b101 && funct7 != 7'b0000000) dec_ok = 1'b0;
                else alu_sel = alu_base;
            end
            OP_BRANCH: begin
                dec.branch  = 1'b1;
                dec.br_type = funct3;
                alu_sel     = ALU_SUB;
                if (funct3 == 3'b010 || funct3 == 3'b011) dec_ok = 1'b0;
            end
            OP_JAL, OP_JALR: begin
                dec.jump       = (opcode == OP_JAL) ? 2'b01 : 2'b10;
                dec.reg_write  = 3'b001;
                dec.result_src = 2'b10;
                dec.alu_src    = 1'b1;
            end
            OP_LUI: begin
                dec.reg_write = 3'b001;
                dec.alu_src   = 1'b1;
                alu_sel       = ALU_PASSB;
            end
            OP_AUIPC: begin
                dec.reg_write = 3'b001;
                dec.alu_src   = 1'b1;
                dec.alu_src_a = 1'b1;
            end
            default: dec_ok = 1'b0;
        endcase
        dec.alu_ctrl = CONTROL_WIDTH'(alu_sel);
        if (!dec_ok) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        dec.valid = 1'b1;
    end

    always_comb begin
        bundle_d = bundle_q;
        if (flush_e) bundle_d = '0;
        else if (!stall_e && !md_hold) bundle_d = valid_d ? dec : '0;
    end

`ifdef CTRL_MULDIV_EN
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [3:0] MD_CNT_INIT = 4'(MD_LATENCY - 1);

    state_t     state_d, state_q;
    logic [3:0] cnt_d, cnt_q;
    logic       dec_md;

    assign dec_md  = (opcode == OP_R) && (funct7 == F7_MULDIV) && !dec.illegal;
    assign md_hold = (state_q == BUSY);
    assign busy_d  = (state_q == BUSY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_e) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (!stall_e) begin
            if (state_q == BUSY) begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = IDLE;
            end else if (valid_d && dec_md && MD_LATENCY > 1) begin
                state_d = BUSY;
                cnt_d   = MD_CNT_INIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign md_hold = 1'b0;
    assign busy_d  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) bundle_q <= '0;
        else     bundle_q <= bundle_d;
    end

    assign valid_e    = bundle_q.valid;
    assign RegWriteE  = bundle_q.reg_write;
    assign MemWriteE  = bundle_q.mem_write;
    assign ResultsrcE = bundle_q.result_src;
    assign ALUctrlE   = bundle_q.alu_ctrl;
    assign ALUsrcE    = bundle_q.alu_src;
    assign ALUsrcAE   = bundle_q.alu_src_a;
    assign JumpE      = bundle_q.jump;
    assign BranchE    = bundle_q.branch;
    assign BrTypeE    = bundle_q.br_type;
    assign IllegalE   = bundle_q.illegal;
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench for ctrl_decode_stage: directed scenarios, then random
// instruction streams compared against an instruction-level reference model.
module tb_ctrl_decode_stage;
    localparam int CW     = 4;
    localparam int IW     = 3;
    localparam int MD_LAT = 4;
`ifdef CTRL_MULDIV_EN
    localparam bit MULDIV_ON = 1'b1;
`else
    localparam bit MULDIV_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1, valid_d = 1'b0, stall_e = 1'b0, flush_e = 1'b0;
    logic [6:0]    opcode = '0, funct7 = '0;
    logic [2:0]    funct3 = '0;
    logic [IW-1:0] ImmSrcD;
    logic          busy_d, valid_e, ALUsrcE, ALUsrcAE, BranchE, IllegalE;
    logic [2:0]    RegWriteE, BrTypeE;
    logic [1:0]    MemWriteE, ResultsrcE, JumpE;
    logic [CW-1:0] ALUctrlE;

    always #5 clk = ~clk;

    ctrl_decode_stage #(.CONTROL_WIDTH(CW), .IMM_WIDTH(IW), .MD_LATENCY(MD_LAT)) dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .stall_e(stall_e), .flush_e(flush_e), .ImmSrcD(ImmSrcD),
        .busy_d(busy_d), .valid_e(valid_e), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .ResultsrcE(ResultsrcE), .ALUctrlE(ALUctrlE), .ALUsrcE(ALUsrcE), .ALUsrcAE(ALUsrcAE),
        .JumpE(JumpE), .BranchE(BranchE), .BrTypeE(BrTypeE), .IllegalE(IllegalE)
    );

    typedef struct packed {
        logic       ill;
        logic [1:0] jump;
        logic       br;
        logic [2:0] brt;
        logic       srca;
        logic       src;
        logic [3:0] alu;
        logic [1:0] res;
        logic [1:0] mw;
        logic [2:0] rw;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] alu_by_f3 [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    logic [3:0] md_by_f3  [8] = '{4'd11, 4'd12, 4'd0, 4'd0, 4'd13, 4'd0, 4'd14, 4'd0};
    logic [6:0] op_pool   [9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    exp_t m_bundle = '0;
    bit   m_valid  = 1'b0;
    int   md_left  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] model_imm(input logic [6:0] op);
        if (op == 7'h23) return 3'd1;
        if (op == 7'h63) return 3'd2;
        if (op == 7'h6F) return 3'd3;
        if (op == 7'h37 || op == 7'h17) return 3'd4;
        return 3'd0;
    endfunction

    function automatic void model_decode(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7, output exp_t e, output bit md);
        bit ok, is_r, shift;
        ok = 1'b1; md = 1'b0; e = '0;
        is_r  = (op == 7'h33);
        shift = (f3 == 3'd1 || f3 == 3'd5);
        if (op == 7'h03) begin
            ok    = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            e.rw  = (f3 < 3) ? 3'(3 - int'(f3)) : 3'(11 - int'(f3));
            e.res = 2'd1;
            e.src = 1'b1;
        end else if (op == 7'h23) begin
            ok    = (f3 < 3);
            e.mw  = 2'(3 - int'(f3));
            e.src = 1'b1;
        end else if (is_r || op == 7'h13) begin
            e.rw  = 3'd1;
            e.src = !is_r;
            if (is_r || shift) begin
                if (f7 == 7'h00) e.alu = alu_by_f3[f3];
                else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'd9;
                else if (f7 == 7'h20 && f3 == 3'd0 && is_r) e.alu = 4'd1;
                else if (f7 == 7'h01 && is_r && MULDIV_ON) begin
                    md    = 1'b1;
                    ok    = (md_by_f3[f3] != 4'd0);
                    e.alu = md_by_f3[f3];
                end else ok = 1'b0;
            end else e.alu = alu_by_f3[f3];
        end else if (op == 7'h63) begin
            ok    = !(f3 == 3'd2 || f3 == 3'd3);
            e.br  = 1'b1;
            e.brt = f3;
            e.alu = 4'd1;
        end else if (op == 7'h6F || op == 7'h67) begin
            e.jump = (op == 7'h6F) ? 2'd1 : 2'd2;
            e.rw   = 3'd1;
            e.res  = 2'd2;
            e.src  = 1'b1;
        end else if (op == 7'h37) begin
            e.alu = 4'd10; e.rw = 3'd1; e.src = 1'b1;
        end else if (op == 7'h17) begin
            e.srca = 1'b1; e.rw = 3'd1; e.src = 1'b1;
        end else ok = 1'b0;
        if (!ok) begin
            e     = '0;
            e.ill = 1'b1;
            md    = 1'b0;
        end
    endfunction

    function automatic void model_edge(input logic r, input logic v, input logic [6:0] op,
                                       input logic [2:0] f3, input logic [6:0] f7,
                                       input logic st, input logic fl);
        exp_t e;
        bit   md;
        if (r || fl) begin
            m_valid = 1'b0; m_bundle = '0; md_left = 0;
        end else if (!st) begin
            if (md_left > 0) md_left--;
            else if (v) begin
                model_decode(op, f3, f7, e, md);
                m_valid  = 1'b1;
                m_bundle = e;
                if (md && MD_LAT > 1) md_left = MD_LAT - 1;
            end else begin
                m_valid = 1'b0; m_bundle = '0;
            end
        end
    endfunction

    task automatic cycle(input logic r, input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic st, input logic fl);
        exp_t obs;
        rst = r; valid_d = v; opcode = op; funct3 = f3; funct7 = f7; stall_e = st; flush_e = fl;
        #1;
        check_eq("imm_src", 32'(ImmSrcD), 32'(model_imm(op)));
        @(posedge clk);
        model_edge(r, v, op, f3, f7, st, fl);
        #1;
        obs = {IllegalE, JumpE, BranchE, BrTypeE, ALUsrcAE, ALUsrcE, ALUctrlE[3:0],
               ResultsrcE, MemWriteE, RegWriteE};
        check_eq("valid_e", 32'(valid_e), 32'(m_valid));
        check_eq("e_bundle", 32'(obs), 32'(m_bundle));
        check_eq("busy_d", 32'(busy_d), 32'(md_left > 0));
    endtask

    initial begin
        int n_busy;
        logic [6:0] op, f7;
        cycle(1, 0, 7'h00, 3'd0, 7'h00, 0, 0);
        check_eq("rst_valid", 32'(valid_e), 32'd0);
        check_eq("rst_busy", 32'(busy_d), 32'd0);

        cycle(0, 1, 7'h03, 3'd2, 7'h00, 0, 0);
        check_eq("lw_valid", 32'(valid_e), 32'd1);
        check_eq("lw_rw", 32'(RegWriteE), 32'd1);
        check_eq("lw_res", 32'(ResultsrcE), 32'd1);
        check_eq("lw_src", 32'(ALUsrcE), 32'd1);
        check_eq("lw_alu", 32'(ALUctrlE), 32'd0);

        cycle(0, 1, 7'h33, 3'd0, 7'h20, 0, 0);
        check_eq("sub_alu", 32'(ALUctrlE), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 7'h33, 3'd6, 7'h00, 1, 0);
            check_eq("sub_held", 32'(ALUctrlE), 32'd1);
        end
        cycle(0, 1, 7'h33, 3'd6, 7'h00, 0, 0);
        check_eq("or_after_stall", 32'(ALUctrlE), 32'd3);

        cycle(0, 1, 7'h7F, 3'd0, 7'h00, 0, 0);
        check_eq("bad_op_ill", 32'(IllegalE), 32'd1);
        check_eq("bad_op_rw", 32'(RegWriteE), 32'd0);
        check_eq("bad_op_mw", 32'(MemWriteE), 32'd0);
        cycle(0, 1, 7'h63, 3'd2, 7'h00, 0, 0);
        check_eq("br010_ill", 32'(IllegalE), 32'd1);
        check_eq("br010_br", 32'(BranchE), 32'd0);

        cycle(0, 1, 7'h23, 3'd0, 7'h00, 0, 0);
        check_eq("sb_mw", 32'(MemWriteE), 32'd3);
        cycle(0, 1, 7'h6F, 3'd0, 7'h00, 1, 1);
        check_eq("flush_wins_valid", 32'(valid_e), 32'd0);
        check_eq("flush_wins_mw", 32'(MemWriteE), 32'd0);

`ifdef CTRL_MULDIV_EN
        cycle(0, 1, 7'h33, 3'd0, 7'h01, 0, 0);
        check_eq("mul_alu", 32'(ALUctrlE), 32'd11);
        n_busy = 0;
        for (int i = 0; i < 20 && busy_d; i++) begin
            n_busy++;
            cycle(0, 1, 7'h33, 3'd4, 7'h00, 0, 0);
        end
        check_eq("mul_busy_len", 32'(n_busy), 32'(MD_LAT - 1));
        check_eq("mul_held", 32'(ALUctrlE), 32'd11);
        cycle(0, 1, 7'h33, 3'd4, 7'h00, 0, 0);
        check_eq("after_mul_xor", 32'(ALUctrlE), 32'd4);

        cycle(0, 1, 7'h33, 3'd1, 7'h01, 0, 0);
        n_busy = 0;
        for (int i = 0; i < 20 && busy_d; i++) begin
            n_busy++;
            cycle(0, 1, 7'h33, 3'd4, 7'h00, (i == 1), 0);
        end
        check_eq("mulh_stall_len", 32'(n_busy), 32'(MD_LAT));

        cycle(0, 1, 7'h33, 3'd4, 7'h01, 0, 0);
        check_eq("div_busy", 32'(busy_d), 32'd1);
        cycle(0, 1, 7'h33, 3'd4, 7'h00, 0, 1);
        check_eq("div_flush_valid", 32'(valid_e), 32'd0);
        check_eq("div_flush_busy", 32'(busy_d), 32'd0);
        check_eq("div_flush_alu", 32'(ALUctrlE), 32'd0);
        cycle(0, 1, 7'h33, 3'd6, 7'h01, 0, 0);
        check_eq("rem_busy", 32'(busy_d), 32'd1);
        cycle(1, 1, 7'h33, 3'd0, 7'h00, 0, 0);
        check_eq("rem_rst_valid", 32'(valid_e), 32'd0);
        check_eq("rem_rst_busy", 32'(busy_d), 32'd0);
`else
        cycle(0, 1, 7'h33, 3'd0, 7'h01, 0, 0);
        check_eq("mul_ill", 32'(IllegalE), 32'd1);
        check_eq("mul_no_busy", 32'(busy_d), 32'd0);
`endif

        for (int i = 0; i < 600; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : op_pool[$urandom_range(0, 8)];
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2:       f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), op,
                  3'($urandom), f7, ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
